// File: rtl/via6522_lite_pkg.sv
// Shared constants for the reduced 6522 VIA: register map, IFR bit positions, ACR/PCR bits.
package via6522_lite_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 16;

    localparam logic [ADDR_W-1:0] VIA_ORB    = 4'h0;
    localparam logic [ADDR_W-1:0] VIA_ORA    = 4'h1;
    localparam logic [ADDR_W-1:0] VIA_DDRB   = 4'h2;
    localparam logic [ADDR_W-1:0] VIA_DDRA   = 4'h3;
    localparam logic [ADDR_W-1:0] VIA_T1CL   = 4'h4;
    localparam logic [ADDR_W-1:0] VIA_T1CH   = 4'h5;
    localparam logic [ADDR_W-1:0] VIA_T1LL   = 4'h6;
    localparam logic [ADDR_W-1:0] VIA_T1LH   = 4'h7;
    localparam logic [ADDR_W-1:0] VIA_T2CL   = 4'h8;
    localparam logic [ADDR_W-1:0] VIA_T2CH   = 4'h9;
    localparam logic [ADDR_W-1:0] VIA_SR     = 4'hA;
    localparam logic [ADDR_W-1:0] VIA_ACR    = 4'hB;
    localparam logic [ADDR_W-1:0] VIA_PCR    = 4'hC;
    localparam logic [ADDR_W-1:0] VIA_IFR    = 4'hD;
    localparam logic [ADDR_W-1:0] VIA_IER    = 4'hE;
    localparam logic [ADDR_W-1:0] VIA_ORA_NH = 4'hF;

    localparam int unsigned IFR_CA1 = 1;
    localparam int unsigned IFR_T2  = 5;
    localparam int unsigned IFR_T1  = 6;
    localparam logic [6:0]  IFR_IMPL_MASK = 7'b110_0010;

    localparam int unsigned ACR_T1_CONT = 6;
    localparam int unsigned ACR_T1_PB7  = 7;
    localparam int unsigned PCR_CA1_POS = 0;

    // Per-bit port readback: driven bits return the output register, inputs return the pin.
    function automatic logic [DATA_W-1:0] port_read(input logic [DATA_W-1:0] ddr,
                                                    input logic [DATA_W-1:0] orv,
                                                    input logic [DATA_W-1:0] pins);
        return (ddr & orv) | (~ddr & pins);
    endfunction

endpackage

// File: rtl/via6522_lite_timer16.sv
// 16-bit down counter with reload latch; fires on 0000->FFFF while armed.
module via6522_lite_timer16
    import via6522_lite_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_latch_lo,
    input  logic              wr_latch_hi,
    input  logic              load,
    input  logic              continuous,
    input  logic [DATA_W-1:0] data,
    input  logic              rd_latch,
    output logic [CNT_W-1:0]  rd_value,
    output logic              fire_c
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] latch;
    logic             armed;
    logic             reload_pend;
    logic             underflow_c;

    // A load or pending reload replaces the decrement, so neither can underflow.
    assign underflow_c = (count == '0) && !load && !reload_pend;
    assign fire_c      = underflow_c && armed;
    assign rd_value    = rd_latch ? latch : count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '1;
            latch       <= '1;
            armed       <= 1'b0;
            reload_pend <= 1'b0;
        end else begin
            if (wr_latch_lo) latch[7:0] <= data;
            if (wr_latch_hi || load) latch[15:8] <= data;

            if (load)             count <= {data, latch[7:0]};
            else if (reload_pend) count <= latch;
            else                  count <= count - CNT_W'(1);

            // Continuous mode spends one extra clk at FFFF before reloading.
            reload_pend <= fire_c && continuous;

            if (load)                           armed <= 1'b1;
            else if (fire_c && !continuous)     armed <= 1'b0;
        end
    end

endmodule

// File: rtl/via6522_lite.sv
// Reduced 6522 VIA: ports A/B with DDRs, T1/T2, CA1 edge flag, IFR/IER, active-low IRQ.
module via6522_lite
    import via6522_lite_pkg::*;
#(
    parameter logic [7:0] SR_READ_VALUE = 8'h00,
    parameter logic [7:0] PCR_RESET     = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs,
    input  logic       rnw,
    input  logic [3:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq_n,
    input  logic [7:0] pa_in,
    output logic [7:0] pa_out,
    output logic [7:0] pa_oe,
    input  logic [7:0] pb_in,
    output logic [7:0] pb_out,
    output logic [7:0] pb_oe,
    input  logic       ca1
);

    logic [7:0] ora, orb, ddra, ddrb, acr, pcr;
    logic [6:0] ifr, ier, ifr_next;
    logic [6:0] ifr_set, soft_clr, hard_clr;
    logic       pb7_level, ca1_s1, ca1_s2, ca1_edge, irq;
    logic       wr_en, rd_en;
    logic       t1_fire, t2_fire;
    logic [15:0] t1_value, t2_value;

    assign wr_en = cs && !rnw;
    assign rd_en = cs && rnw;

    via6522_lite_timer16 u_t1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_latch_lo(wr_en && (addr == VIA_T1CL || addr == VIA_T1LL)),
        .wr_latch_hi(wr_en && addr == VIA_T1LH),
        .load       (wr_en && addr == VIA_T1CH),
        .continuous (acr[ACR_T1_CONT]),
        .data       (din),
        .rd_latch   (addr == VIA_T1LL || addr == VIA_T1LH),
        .rd_value   (t1_value),
        .fire_c     (t1_fire)
    );

    via6522_lite_timer16 u_t2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_latch_lo(wr_en && addr == VIA_T2CL),
        .wr_latch_hi(1'b0),
        .load       (wr_en && addr == VIA_T2CH),
        .continuous (1'b0),
        .data       (din),
        .rd_latch   (1'b0),
        .rd_value   (t2_value),
        .fire_c     (t2_fire)
    );

    // Edge taken across the two synchroniser stages keeps pin-to-IFR latency at 2 clks.
    assign ca1_edge = pcr[PCR_CA1_POS] ? (ca1_s1 && !ca1_s2) : (!ca1_s1 && ca1_s2);

    // Read-type clears lose to a same-cycle event; T1CH/T2CH/IFR writes win over it.
    always_comb begin
        ifr_set  = '0;
        soft_clr = '0;
        hard_clr = '0;
        ifr_set[IFR_T1]  = t1_fire;
        ifr_set[IFR_T2]  = t2_fire;
        ifr_set[IFR_CA1] = ca1_edge;
        if (cs && (addr == VIA_ORB || addr == VIA_ORA)) soft_clr[IFR_CA1] = 1'b1;
        if (rd_en && addr == VIA_T1CL) soft_clr[IFR_T1] = 1'b1;
        if (rd_en && addr == VIA_T2CL) soft_clr[IFR_T2] = 1'b1;
        if (wr_en && addr == VIA_T1LH) soft_clr[IFR_T1] = 1'b1;
        if (wr_en && addr == VIA_T1CH) hard_clr[IFR_T1] = 1'b1;
        if (wr_en && addr == VIA_T2CH) hard_clr[IFR_T2] = 1'b1;
        if (wr_en && addr == VIA_IFR)  hard_clr = hard_clr | din[6:0];
        ifr_next = (((ifr & ~soft_clr) | ifr_set) & ~hard_clr) & IFR_IMPL_MASK;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ora       <= '0;
            orb       <= '0;
            ddra      <= '0;
            ddrb      <= '0;
            acr       <= '0;
            pcr       <= PCR_RESET;
            ier       <= '0;
            ifr       <= '0;
            pb7_level <= 1'b1;
            ca1_s1    <= 1'b0;
            ca1_s2    <= 1'b0;
        end else begin
            ca1_s1 <= ca1;
            ca1_s2 <= ca1_s1;
            ifr    <= ifr_next;

            if (wr_en && addr == VIA_T1CH) pb7_level <= 1'b0;
            else if (t1_fire)              pb7_level <= acr[ACR_T1_CONT] ? !pb7_level : 1'b1;

            if (wr_en) begin
                case (addr)
                    VIA_ORB:             orb  <= din;
                    VIA_ORA, VIA_ORA_NH: ora  <= din;
                    VIA_DDRB:            ddrb <= din;
                    VIA_DDRA:            ddra <= din;
                    VIA_ACR:             acr  <= din;
                    VIA_PCR:             pcr  <= din;
                    VIA_IER:             ier  <= din[7] ? (ier | din[6:0]) : (ier & ~din[6:0]);
                    default: ;
                endcase
            end
        end
    end

    assign irq    = |(ifr & ier);
    assign irq_n  = !irq;
    assign pa_out = ora;
    assign pa_oe  = ddra;
    assign pb_out = acr[ACR_T1_PB7] ? {pb7_level, orb[6:0]} : orb;
    assign pb_oe  = ddrb | {acr[ACR_T1_PB7], 7'b0};

    // Read mux is purely combinational from the current address and state.
    always_comb begin
        dout = '0;
        case (addr)
            VIA_ORB:             dout = port_read(ddrb, orb, pb_in);
            VIA_ORA, VIA_ORA_NH: dout = port_read(ddra, ora, pa_in);
            VIA_DDRB:            dout = ddrb;
            VIA_DDRA:            dout = ddra;
            VIA_T1CL, VIA_T1LL:  dout = t1_value[7:0];
            VIA_T1CH, VIA_T1LH:  dout = t1_value[15:8];
            VIA_T2CL:            dout = t2_value[7:0];
            VIA_T2CH:            dout = t2_value[15:8];
            VIA_SR:              dout = SR_READ_VALUE;
            VIA_ACR:             dout = acr;
            VIA_PCR:             dout = pcr;
            VIA_IFR:             dout = {irq, ifr};
            VIA_IER:             dout = {1'b1, ier};
            default:             dout = '0;
        endcase
    end

endmodule

// File: tb/tb_via6522_lite.sv
// Directed bench for via6522_lite: register table plus timed timer/CA1 sequences.
module tb_via6522_lite;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cs, rnw, ca1;
    logic [3:0] addr;
    logic [7:0] din, dout, pa_in, pa_out, pa_oe, pb_in, pb_out, pb_oe;
    logic       irq_n;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic       is_wr;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    via6522_lite dut (
        .clk    (clk),
        .reset_n(reset_n),
        .cs     (cs),
        .rnw    (rnw),
        .addr   (addr),
        .din    (din),
        .dout   (dout),
        .irq_n  (irq_n),
        .pa_in  (pa_in),
        .pa_out (pa_out),
        .pa_oe  (pa_oe),
        .pb_in  (pb_in),
        .pb_out (pb_out),
        .pb_oe  (pb_oe),
        .ca1    (ca1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; the access is taken at the following posedge.
    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        cs = 1'b1; rnw = 1'b0; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; rnw = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        cs = 1'b1; rnw = 1'b1; addr = a;
        #1 d = dout;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        addr = a;
        #1 d = dout;
    endtask

    task automatic wait_irq(input int max_cyc, output int t);
        t = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!irq_n) begin
                t = cyc;
                return;
            end
        end
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] rst_exp [16];
        int t0, ta, tb, tc, lows;

        rst_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                    8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00};

        vecs.push_back('{1'b1, 4'h2, 8'hF0, 8'h00});
        vecs.push_back('{1'b1, 4'h0, 8'hA5, 8'h00});
        vecs.push_back('{1'b0, 4'h0, 8'h00, 8'hAC});
        vecs.push_back('{1'b1, 4'h3, 8'h0F, 8'h00});
        vecs.push_back('{1'b1, 4'h1, 8'h5A, 8'h00});
        vecs.push_back('{1'b0, 4'h1, 8'h00, 8'hCA});
        vecs.push_back('{1'b0, 4'hF, 8'h00, 8'hCA});
        vecs.push_back('{1'b0, 4'h2, 8'h00, 8'hF0});
        vecs.push_back('{1'b0, 4'h3, 8'h00, 8'h0F});
        vecs.push_back('{1'b1, 4'hA, 8'hFF, 8'h00});
        vecs.push_back('{1'b0, 4'hA, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 4'hC, 8'h0E, 8'h00});
        vecs.push_back('{1'b0, 4'hC, 8'h00, 8'h0E});
        vecs.push_back('{1'b1, 4'hC, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 4'hE, 8'h83, 8'h00});
        vecs.push_back('{1'b0, 4'hE, 8'h00, 8'h83});
        vecs.push_back('{1'b1, 4'hE, 8'h03, 8'h00});
        vecs.push_back('{1'b0, 4'hE, 8'h00, 8'h80});
        vecs.push_back('{1'b1, 4'h6, 8'h34, 8'h00});
        vecs.push_back('{1'b1, 4'h7, 8'h12, 8'h00});
        vecs.push_back('{1'b0, 4'h6, 8'h00, 8'h34});
        vecs.push_back('{1'b0, 4'h7, 8'h00, 8'h12});
        vecs.push_back('{1'b1, 4'hB, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 4'hB, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 4'hD, 8'h00, 8'h00});

        reset_n = 1'b0; cs = 1'b0; rnw = 1'b1; addr = '0; din = '0;
        pa_in = '0; pb_in = '0; ca1 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state, read while reset is held
        cs = 1'b1;
        for (int i = 0; i < 16; i++) begin
            peek(4'(i), v);
            check($sformatf("reset_reg%0h", i), 32'(v), 32'(rst_exp[i]));
        end
        cs = 1'b0;
        check("reset_irq_n", 32'(irq_n), 32'd1);
        check("reset_ports", {pa_out, pa_oe, pb_out, pb_oe}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Register table: DDR mixing, IER set/clear, latches, SR
        pb_in = 8'h3C;
        pa_in = 8'hC3;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) begin
                bus_write(vecs[i].a, vecs[i].d);
            end else begin
                bus_read(vecs[i].a, v);
                check($sformatf("vec%0d_reg%0h", i, vecs[i].a), 32'(v), 32'(vecs[i].exp));
            end
        end
        check("pb_out_orb", 32'(pb_out), 32'hA5);
        check("pb_oe_ddrb", 32'(pb_oe), 32'hF0);
        check("pa_out_ora", 32'(pa_out), 32'h5A);
        check("pa_oe_ddra", 32'(pa_oe), 32'h0F);

        // T1 one-shot: IRQ exactly 6 clks after T1CH write
        bus_write(4'hE, 8'hC0);
        bus_write(4'h4, 8'h05);
        bus_write(4'h5, 8'h00);
        repeat (5) @(negedge clk);
        check("t1os_irq_before", 32'(irq_n), 32'd1);
        @(negedge clk);
        check("t1os_irq_at6", 32'(irq_n), 32'd0);
        bus_read(4'h4, v);
        check("t1os_cnt_lo", 32'(v), 32'hFF);
        check("t1os_irq_cleared", 32'(irq_n), 32'd1);
        lows = 0;
        repeat (70000) begin
            @(negedge clk);
            if (!irq_n) lows++;
        end
        check("t1os_no_rearm", 32'(lows), 32'd0);

        // T1 continuous with PB7 toggle, period latch+2
        bus_write(4'h2, 8'h00);
        bus_write(4'hB, 8'hC0);
        check("t1c_pb_oe7", 32'(pb_oe), 32'h80);
        check("t1c_pb7_idle", 32'(pb_out), 32'hA5);
        bus_write(4'h6, 8'h10);
        bus_write(4'h5, 8'h00);
        t0 = cyc;
        check("t1c_pb7_load", 32'(pb_out), 32'h25);
        wait_irq(40, ta);
        check("t1c_first", 32'(ta - t0), 32'd17);
        check("t1c_pb7_1", 32'(pb_out), 32'hA5);
        bus_write(4'hD, 8'h40);
        wait_irq(40, tb);
        check("t1c_period1", 32'(tb - ta), 32'd18);
        check("t1c_pb7_2", 32'(pb_out), 32'h25);
        bus_write(4'hD, 8'h40);
        wait_irq(40, tc);
        check("t1c_period2", 32'(tc - tb), 32'd18);
        check("t1c_pb7_3", 32'(pb_out), 32'hA5);
        bus_write(4'hB, 8'h00);
        bus_write(4'hE, 8'h40);
        repeat (40) @(negedge clk);
        bus_write(4'hD, 8'h7F);
        bus_read(4'hD, v);
        check("t1c_quiet_ifr", 32'(v), 32'h00);

        // T2 one-shot with IER disabled, then IFR write clear
        bus_write(4'h8, 8'h03);
        bus_write(4'h9, 8'h00);
        repeat (6) @(negedge clk);
        bus_read(4'hD, v);
        check("t2_ifr", 32'(v), 32'h20);
        check("t2_irq_masked", 32'(irq_n), 32'd1);
        bus_write(4'hD, 8'h20);
        bus_read(4'hD, v);
        check("t2_ifr_clr", 32'(v), 32'h00);

        // IFR write in the underflow cycle wins
        bus_write(4'h9, 8'h00);
        repeat (3) @(negedge clk);
        bus_write(4'hD, 8'h20);
        bus_read(4'hD, v);
        check("t2_wr_wins", 32'(v), 32'h00);
        bus_read(4'h8, v);
        check("t2_freerun", 32'(v), 32'hFE);

        // CA1 rising edge: 2-clk latency, read-clear in the set cycle loses
        bus_write(4'hC, 8'h01);
        ca1 = 1'b1;
        @(negedge clk);
        peek(4'hD, v);
        check("ca1_lat1", 32'(v), 32'h00);
        @(negedge clk);
        peek(4'hD, v);
        check("ca1_lat2", 32'(v), 32'h02);
        bus_read(4'h1, v);
        bus_read(4'hD, v);
        check("ca1_rd_clr", 32'(v), 32'h00);
        ca1 = 1'b0;
        repeat (4) @(negedge clk);
        bus_read(4'hD, v);
        check("ca1_fall_ign", 32'(v), 32'h00);
        ca1 = 1'b1;
        @(negedge clk);
        bus_read(4'h1, v);
        bus_read(4'hD, v);
        check("ca1_set_wins", 32'(v), 32'h02);
        bus_read(4'hF, v);
        bus_read(4'hD, v);
        check("ca1_regf_keep", 32'(v), 32'h02);
        bus_write(4'hE, 8'h82);
        check("ca1_irq", 32'(irq_n), 32'd0);
        bus_read(4'hD, v);
        check("ca1_ifr_irq", 32'(v), 32'h82);
        bus_read(4'h1, v);
        bus_read(4'hD, v);
        check("ca1_final_clr", 32'(v), 32'h00);
        check("ca1_irq_off", 32'(irq_n), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
